// File: rtl/usb_serial_stream_bridge.sv
// usb_serial_stream_bridge
//   User-side endpoint of the USB CDC serial byte interface. Two FIFOs
//   decouple the application valid/ready streams from the serial core's
//   put/free strobes. IN data is packetised: tx_flush ends a packet after
//   MAX_PACKET bytes, or once the TX FIFO has sat empty for FLUSH_TIMEOUT
//   cycles with a partial packet outstanding.
// Ports
//   clk_48mhz, reset_n          clock, async active-low reset
//   in_data/in_valid/in_ready   user -> host byte stream
//   out_data/out_valid/out_ready host -> user byte stream
//   tx_free/tx_put/tx_data/tx_flush  serial core TX side
//   rx_free/rx_put/rx_data      serial core RX side
//   tx_level/rx_level           FIFO occupancy (0..DEPTH)
module usb_serial_stream_bridge #(
    parameter int TX_DEPTH      = 16,
    parameter int RX_DEPTH      = 16,
    parameter int MAX_PACKET    = 64,
    parameter int FLUSH_TIMEOUT = 48000
) (
    input  logic                        clk_48mhz,
    input  logic                        reset_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        tx_free,
    output logic                        tx_put,
    output logic [7:0]                  tx_data,
    output logic                        tx_flush,
    output logic                        rx_free,
    input  logic                        rx_put,
    input  logic [7:0]                  rx_data,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int IW    = $clog2(FLUSH_TIMEOUT);

    localparam logic [TX_AW:0]  TX_FULL   = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0]  RX_FULL   = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0]  TX_ONE    = (TX_AW+1)'(1);
    localparam logic [RX_AW:0]  RX_ONE    = (RX_AW+1)'(1);
    localparam logic [6:0]      MAX_PKT   = 7'(MAX_PACKET);
    localparam logic [IW-1:0]   IDLE_LAST = IW'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    // Reset asserts asynchronously and releases two clocks later, so no
    // flop leaves reset on a different edge from its neighbours.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic             tx_push, tx_empty;

    // in_ready looks only at the level: a full FIFO refuses a byte even
    // when a pop is happening in the same cycle.
    assign in_ready = rst_n_int && (tx_level < TX_FULL);
    assign tx_push  = in_valid && in_ready;
    assign tx_empty = (tx_level == '0);
    assign tx_data  = tx_mem[tx_rd_ptr];

    always_ff @(posedge clk_48mhz) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk_48mhz or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_put)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push, tx_put})
                2'b10:   tx_level <= tx_level + TX_ONE;
                2'b01:   tx_level <= tx_level - TX_ONE;
                default: ;
            endcase
        end
    end

    // ---------------- packetiser ----------------
    state_t        state_q, state_d;
    logic [6:0]    pkt_cnt, pkt_inc;
    logic [IW-1:0] idle_cnt;

    assign pkt_inc = pkt_cnt + 7'd1;
    assign tx_put  = (state_q != FLUSH) && !tx_empty && tx_free;

    always_comb begin
        state_d  = state_q;
        tx_flush = 1'b0;
        case (state_q)
            IDLE, SEND: begin
                if (tx_put && pkt_inc == MAX_PKT)
                    state_d = FLUSH;
                else if (tx_put)
                    state_d = SEND;
                // IDLE has pkt_cnt==0, so only SEND may time out; this is
                // what keeps zero-length packets from ever being flushed.
                else if (state_q == SEND && tx_empty && idle_cnt == IDLE_LAST)
                    state_d = FLUSH;
            end
            FLUSH: begin
                tx_flush = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= IDLE;
            pkt_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FLUSH) begin
                pkt_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                if (tx_put) pkt_cnt <= pkt_inc;
                // A stalled (tx_free=0) non-empty FIFO does not count as idle.
                if (tx_put || tx_push)
                    idle_cnt <= '0;
                else if (pkt_cnt != '0 && tx_empty)
                    idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic             rx_wr, rx_rd;

    // rx_put while full is a core protocol error; the byte is dropped.
    assign rx_free   = rst_n_int && (rx_level < RX_FULL);
    assign rx_wr     = rx_put && rx_free;
    assign out_valid = (rx_level != '0);
    assign rx_rd     = out_valid && out_ready;
    assign out_data  = rx_mem[rx_rd_ptr];

    always_ff @(posedge clk_48mhz) begin
        if (rx_wr) rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk_48mhz or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_wr) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_rd) rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_wr, rx_rd})
                2'b10:   rx_level <= rx_level + RX_ONE;
                2'b01:   rx_level <= rx_level - RX_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_serial_stream_bridge.sv
// Directed bench for usb_serial_stream_bridge. The idle timeout is shortened
// to T cycles so that several timeout flushes fit in a short run.
module tb_usb_serial_stream_bridge;
    localparam int T = 100;

    logic       clk_48mhz = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       tx_free;
    logic       tx_put;
    logic [7:0] tx_data;
    logic       tx_flush;
    logic       rx_free;
    logic       rx_put;
    logic [7:0] rx_data;
    logic [4:0] tx_level;
    logic [4:0] rx_level;

    int tests = 0;
    int fails = 0;

    usb_serial_stream_bridge #(
        .TX_DEPTH(16), .RX_DEPTH(16), .MAX_PACKET(64), .FLUSH_TIMEOUT(T)
    ) dut (
        .clk_48mhz(clk_48mhz), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .tx_free(tx_free), .tx_put(tx_put), .tx_data(tx_data), .tx_flush(tx_flush),
        .rx_free(rx_free), .rx_put(rx_put), .rx_data(rx_data),
        .tx_level(tx_level), .rx_level(rx_level)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit later, well away from either clock edge.
    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic wait_flush(input int bound, output int cycles);
        cycles = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk_48mhz);
            #2;
            if (tx_flush === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        int n, nf, push_idx, exp_idx, cyc, nput;
        int flush_at [3];

        reset_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        tx_free = 1'b0; rx_put = 1'b0; rx_data = '0;

        // ---- reset state ----
        tick(); tick(); #1;
        chk("rst_in_ready",  32'(in_ready), 0);
        chk("rst_rx_free",   32'(rx_free), 0);
        chk("rst_tx_put",    32'(tx_put), 0);
        chk("rst_tx_flush",  32'(tx_flush), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_tx_level",  32'(tx_level), 0);
        chk("rst_rx_level",  32'(rx_level), 0);
        tick(); reset_n = 1'b1;
        tick(); tick(); tick(); #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        chk("rel_rx_free",  32'(rx_free), 1);

        // ---- 3 bytes then timeout flush ----
        tick(); tx_free = 1'b1; in_valid = 1'b1; in_data = 8'h41; #1;
        chk("t1_put_c0", 32'(tx_put), 0);
        tick(); in_data = 8'h42; #1;
        chk("t1_put_c1", 32'(tx_put), 1);
        chk("t1_dat_c1", 32'(tx_data), 32'h41);
        tick(); in_data = 8'h43; #1;
        chk("t1_put_c2", 32'(tx_put), 1);
        chk("t1_dat_c2", 32'(tx_data), 32'h42);
        tick(); in_valid = 1'b0; #1;
        chk("t1_put_c3", 32'(tx_put), 1);
        chk("t1_dat_c3", 32'(tx_data), 32'h43);
        tick(); #1;
        chk("t1_put_c4",  32'(tx_put), 0);
        chk("t1_level_0", 32'(tx_level), 0);
        chk("t1_noflush", 32'(tx_flush), 0);
        wait_flush(T + 20, n);
        chk("t1_flush_delay", 32'(n), 32'(T));
        tick(); #1;
        chk("t1_flush_1cyc", 32'(tx_flush), 0);
        chk("t1_pkt_cnt0",   32'(dut.pkt_cnt), 0);

        // ---- 130-byte stream ----
        nf = 0; push_idx = 0; exp_idx = 0; cyc = 0;
        while (nf < 3 && cyc < 1000) begin
            tick();
            in_valid = (push_idx < 130);
            in_data  = 8'(push_idx);
            #1;
            if (tx_put === 1'b1) begin
                chk("t2_data", 32'(tx_data), 32'(exp_idx & 8'hFF));
                exp_idx++;
            end
            if (tx_flush === 1'b1) begin
                chk("t2_flush_no_put", 32'(tx_put), 0);
                flush_at[nf] = exp_idx;
                nf++;
            end
            if (in_valid && in_ready) push_idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("t2_nflush", 32'(nf), 3);
        chk("t2_flush1_at", 32'(flush_at[0]), 64);
        chk("t2_flush2_at", 32'(flush_at[1]), 128);
        chk("t2_flush3_at", 32'(flush_at[2]), 130);
        chk("t2_bytes", 32'(exp_idx), 130);

        // ---- stalled core, overfill TX ----
        tick(); tx_free = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick(); in_valid = 1'b1; in_data = 8'(32'hA0 + i); #1;
            if (i < 16) chk("t3_in_ready_hi", 32'(in_ready), 1);
            else begin
                chk("t3_in_ready_lo", 32'(in_ready), 0);
                chk("t3_level16", 32'(tx_level), 16);
            end
        end
        tick(); in_valid = 1'b0; #1;
        chk("t3_level_hold", 32'(tx_level), 16);
        nf = 0; nput = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            if (tx_flush === 1'b1) nf++;
            if (tx_put === 1'b1) nput++;
        end
        chk("t3_no_flush", 32'(nf), 0);
        chk("t3_no_put", 32'(nput), 0);
        tick(); tx_free = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t3_drain_put", 32'(tx_put), 1);
            chk("t3_drain_dat", 32'(tx_data), 32'hA0 + 32'(i));
            tick();
        end
        #1;
        chk("t3_empty", 32'(tx_level), 0);
        wait_flush(T + 20, n);
        chk("t3_flush_delay", 32'(n), 32'(T));

        // ---- RX fill, overflow, drain ----
        for (int i = 0; i < 16; i++) begin
            tick(); rx_put = 1'b1; rx_data = 8'(32'h10 + i); #1;
            chk("t4_rx_free_hi", 32'(rx_free), 1);
        end
        tick(); rx_put = 1'b1; rx_data = 8'hEE; #1;
        chk("t4_rx_free_lo", 32'(rx_free), 0);
        chk("t4_level16", 32'(rx_level), 16);
        tick(); rx_put = 1'b0; #1;
        chk("t4_drop_level", 32'(rx_level), 16);
        chk("t4_head", 32'(out_data), 32'h10);
        out_ready = 1'b1; #1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_valid", 32'(out_valid), 1);
            chk("t4_data", 32'(out_data), 32'h10 + 32'(i));
            tick(); #1;
            if (i == 0) chk("t4_free_again", 32'(rx_free), 1);
        end
        chk("t4_empty_valid", 32'(out_valid), 0);
        chk("t4_empty_level", 32'(rx_level), 0);

        // ---- simultaneous push/pop at level 5 ----
        tick(); tx_free = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            in_valid = 1'b1; in_data = 8'(32'h60 + k);
            rx_put = 1'b1;   rx_data = 8'(32'h80 + k);
        end
        tick(); in_valid = 1'b0; rx_put = 1'b0; #1;
        chk("t5_tx_lvl5", 32'(tx_level), 5);
        chk("t5_rx_lvl5", 32'(rx_level), 5);
        for (int k = 0; k < 20; k++) begin
            tick();
            tx_free = 1'b1; out_ready = 1'b1;
            in_valid = 1'b1; in_data = 8'(32'h65 + k);
            rx_put = 1'b1;   rx_data = 8'(32'h85 + k);
            #1;
            chk("t5_tx_put", 32'(tx_put), 1);
            chk("t5_tx_dat", 32'(tx_data), 32'h60 + 32'(k));
            chk("t5_rx_dat", 32'(out_data), 32'h80 + 32'(k));
            chk("t5_tx_lvl", 32'(tx_level), 5);
            chk("t5_rx_lvl", 32'(rx_level), 5);
        end
        tick(); in_valid = 1'b0; rx_put = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_tx_tail", 32'(tx_data), 32'h74 + 32'(k));
            chk("t5_rx_tail", 32'(out_data), 32'h94 + 32'(k));
            tick();
        end
        #1;
        chk("t5_tx_empty", 32'(tx_level), 0);
        chk("t5_rx_empty", 32'(rx_level), 0);
        wait_flush(T + 20, n);
        chk("t5_flush_delay", 32'(n), 32'(T));

        // ---- reset mid-packet ----
        tick(); tx_free = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            in_valid = 1'b1; in_data = 8'(32'hC0 + k);
            rx_put = (k < 3); rx_data = 8'(32'hD0 + k);
        end
        tick(); in_valid = 1'b0; rx_put = 1'b0; tx_free = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t6_dat", 32'(tx_data), 32'hC0 + 32'(k));
            tick();
        end
        tx_free = 1'b0; #1;
        chk("t6_tx_lvl4", 32'(tx_level), 4);
        chk("t6_rx_lvl3", 32'(rx_level), 3);
        chk("t6_pkt10", 32'(dut.pkt_cnt), 10);
        tx_free = 1'b1; #1;
        chk("t6_put_pre", 32'(tx_put), 1);
        reset_n = 1'b0; #1;
        chk("t6_async_put",    32'(tx_put), 0);
        chk("t6_async_flush",  32'(tx_flush), 0);
        chk("t6_async_inrdy",  32'(in_ready), 0);
        chk("t6_async_rxfree", 32'(rx_free), 0);
        chk("t6_async_oval",   32'(out_valid), 0);
        chk("t6_async_txlvl",  32'(tx_level), 0);
        chk("t6_async_rxlvl",  32'(rx_level), 0);
        nf = 0;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            if (tx_flush === 1'b1) nf++;
        end
        tick(); reset_n = 1'b1;
        tick(); tick(); tick(); #1;
        chk("t6_rel_inrdy", 32'(in_ready), 1);
        chk("t6_rel_txlvl", 32'(tx_level), 0);
        chk("t6_rel_rxlvl", 32'(rx_level), 0);
        for (int k = 0; k < T + 50; k++) begin
            tick(); #1;
            if (tx_flush === 1'b1) nf++;
        end
        chk("t6_no_flush", 32'(nf), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
